ps_regfile_wb: RTL and testbench

- Data register file at the consuming end of the compute-decode interface.
- Accepts the decoder's combinational read and write addresses and its registered one-hot write enables (ALU / MUL / shifter).
- Serves two operand read ports to the compute units and commits unit results one cycle after decode.
- Also accepts a universal-register transfer write from the program sequencer.

---
 rtl/ps_rf_pkg.sv | 15 +
 rtl/ps_rf_wb_mux.sv | 33 +++
 rtl/ps_regfile_wb.sv | 102 ++++++++++
 tb/tb_ps_regfile_wb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps_rf_pkg.sv
// Shared constants for the compute-decode register file write-back slice.
package ps_rf_pkg;

  // Datapath and address widths of the data register file
  localparam int RF_DW    = 16;
  localparam int RF_AW    = 4;
  localparam int RF_DEPTH = 1 << RF_AW;

  // Bit positions inside the registered one-hot write-enable vector
  localparam int WEN_ALU  = 0;
  localparam int WEN_MUL  = 1;
  localparam int WEN_SHF  = 2;
  localparam int WEN_W    = 3;

endpackage : ps_rf_pkg

// File: rtl/ps_rf_wb_mux.sv
// 3:1 priority select of compute-unit results (shifter > MUL > ALU).
// Shared by the array write path and the optional read bypass path.
module ps_rf_wb_mux
  import ps_rf_pkg::*;
#(
  parameter int DW = RF_DW
) (
  input  logic [WEN_W-1:0] wrt_en,
  input  logic [DW-1:0]    alu_dt,
  input  logic [DW-1:0]    mul_dt,
  input  logic [DW-1:0]    shf_dt,
  output logic [DW-1:0]    sel_dt,
  output logic             col
);

  // Priority data select; ALU result is the fall-through when nothing else is enabled
  always_comb begin
    sel_dt = alu_dt;
    if (wrt_en[WEN_SHF]) begin
      sel_dt = shf_dt;
    end else if (wrt_en[WEN_MUL]) begin
      sel_dt = mul_dt;
    end
  end

  // More than one enable bit set means the decoder broke its one-hot promise
  always_comb begin
    col = (wrt_en[WEN_ALU] & wrt_en[WEN_MUL]) |
          (wrt_en[WEN_ALU] & wrt_en[WEN_SHF]) |
          (wrt_en[WEN_MUL] & wrt_en[WEN_SHF]);
  end

endmodule : ps_rf_wb_mux

// File: rtl/ps_regfile_wb.sv
// Data register file at the consuming end of the compute-decode interface.
// Compute results commit one cycle after decode; the sequencer transfer write
// commits in its own cycle and loses to a compute write on the same address.
// Optional feature macro: RF_BYPASS_EN (read ports forward data committing this cycle).
module ps_regfile_wb
  import ps_rf_pkg::*;
#(
  parameter int RF_DW = ps_rf_pkg::RF_DW,
  parameter int RF_AW = ps_rf_pkg::RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] ps_rf_rd_a0,
  input  logic [RF_AW-1:0] ps_rf_rd_a1,
  input  logic [RF_AW-1:0] ps_rf_wrt_a,
  input  logic [2:0]       ps_rf_wrt_en,
  input  logic [RF_DW-1:0] alu_rf_dt,
  input  logic [RF_DW-1:0] mul_rf_dt,
  input  logic [RF_DW-1:0] shf_rf_dt,
  input  logic             ps_ureg_wrt_en,
  input  logic [RF_AW-1:0] ps_ureg_wrt_a,
  input  logic [RF_DW-1:0] ps_ureg_dt,
  output logic [RF_DW-1:0] rf_dt0,
  output logic [RF_DW-1:0] rf_dt1,
  output logic             rf_wrt_col
);

  localparam int DEPTH = 1 << RF_AW;

  logic [RF_AW-1:0] wrt_a_q;
  logic [RF_DW-1:0] cmp_dt;
  logic             cmp_col;
  logic             cmp_we;
  logic [RF_DW-1:0] rf_mem [DEPTH];

  assign cmp_we = |ps_rf_wrt_en;

  ps_rf_wb_mux #(
    .DW     (RF_DW)
  ) u_wb_mux (
    .wrt_en (ps_rf_wrt_en),
    .alu_dt (alu_rf_dt),
    .mul_dt (mul_rf_dt),
    .shf_dt (shf_rf_dt),
    .sel_dt (cmp_dt),
    .col    (cmp_col)
  );

  // Delay the decode-cycle write address so it lines up with the registered enables
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrt_a_q <= '0;
    end else begin
      wrt_a_q <= ps_rf_wrt_a;
    end
  end

  // Sticky collision flag: once any multi-hot enable is seen it holds until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wrt_col <= 1'b0;
    end else if (cmp_col) begin
      rf_wrt_col <= 1'b1;
    end
  end

  // One storage word per address; compute write beats a same-address transfer write
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [RF_DW-1:0] word_reg;

      // Commit the compute result or the transfer word addressed to this entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else if (cmp_we && (wrt_a_q == RF_AW'(gi))) begin
          word_reg <= cmp_dt;
        end else if (ps_ureg_wrt_en && (ps_ureg_wrt_a == RF_AW'(gi))) begin
          word_reg <= ps_ureg_dt;
        end
      end

      assign rf_mem[gi] = word_reg;
    end
  endgenerate

  // Combinational operand reads, optionally forwarding this cycle's pending commit
  always_comb begin
    rf_dt0 = rf_mem[ps_rf_rd_a0];
    rf_dt1 = rf_mem[ps_rf_rd_a1];
`ifdef RF_BYPASS_EN
    // Transfer first so the compute result overrides it, matching write priority
    if (ps_ureg_wrt_en && (ps_ureg_wrt_a == ps_rf_rd_a0)) rf_dt0 = ps_ureg_dt;
    if (ps_ureg_wrt_en && (ps_ureg_wrt_a == ps_rf_rd_a1)) rf_dt1 = ps_ureg_dt;
    if (cmp_we && (wrt_a_q == ps_rf_rd_a0)) rf_dt0 = cmp_dt;
    if (cmp_we && (wrt_a_q == ps_rf_rd_a1)) rf_dt1 = cmp_dt;
`else
    // Reads see the pre-write array; dependents must issue two cycles after the producer
`endif
  end

endmodule : ps_regfile_wb

// File: tb/tb_ps_regfile_wb.sv
// Self-checking bench for ps_regfile_wb: table of write vectors with expected
// read-back values pushed to a scoreboard queue, plus hand-written sequences
// for latency, collision stickiness and asynchronous reset.
module tb_ps_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ps_rf_rd_a0, ps_rf_rd_a1, ps_rf_wrt_a, ps_ureg_wrt_a;
  logic [2:0]  ps_rf_wrt_en;
  logic [15:0] alu_rf_dt, mul_rf_dt, shf_rf_dt, ps_ureg_dt;
  logic        ps_ureg_wrt_en;
  logic [15:0] rf_dt0, rf_dt1;
  logic        rf_wrt_col;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       nm;
    logic [3:0]  wa;
    logic [2:0]  en;
    logic [15:0] alu, mul, shf;
    logic        ue;
    logic [3:0]  ua;
    logic [15:0] ud;
    logic [3:0]  ca0;
    logic [15:0] cd0;
    logic [3:0]  ca1;
    logic [15:0] cd1;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  a0;
    logic [15:0] d0;
    logic [3:0]  a1;
    logic [15:0] d1;
  } sb_t;

  vec_t vecs [8];
  sb_t  sb_q [$];

  ps_regfile_wb dut (
    .clk            (clk),
    .rst            (rst),
    .ps_rf_rd_a0    (ps_rf_rd_a0),
    .ps_rf_rd_a1    (ps_rf_rd_a1),
    .ps_rf_wrt_a    (ps_rf_wrt_a),
    .ps_rf_wrt_en   (ps_rf_wrt_en),
    .alu_rf_dt      (alu_rf_dt),
    .mul_rf_dt      (mul_rf_dt),
    .shf_rf_dt      (shf_rf_dt),
    .ps_ureg_wrt_en (ps_ureg_wrt_en),
    .ps_ureg_wrt_a  (ps_ureg_wrt_a),
    .ps_ureg_dt     (ps_ureg_dt),
    .rf_dt0         (rf_dt0),
    .rf_dt1         (rf_dt1),
    .rf_wrt_col     (rf_wrt_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("[TB] ok %s: %h", nm, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ps_rf_wrt_a    = 4'h0;
    ps_rf_wrt_en   = 3'b000;
    alu_rf_dt      = 16'h0;
    mul_rf_dt      = 16'h0;
    shf_rf_dt      = 16'h0;
    ps_ureg_wrt_en = 1'b0;
    ps_ureg_wrt_a  = 4'h0;
    ps_ureg_dt     = 16'h0;
  endtask

  // Decode cycle with address, next cycle with enables/data (+ optional transfer), then idle
  task automatic do_write(input logic [3:0] wa, input logic [2:0] en,
                          input logic [15:0] alu, input logic [15:0] mul, input logic [15:0] shf,
                          input logic ue, input logic [3:0] ua, input logic [15:0] ud);
    step();
    idle_inputs();
    ps_rf_wrt_a = wa;
    step();
    ps_rf_wrt_a    = 4'h0;
    ps_rf_wrt_en   = en;
    alu_rf_dt      = alu;
    mul_rf_dt      = mul;
    shf_rf_dt      = shf;
    ps_ureg_wrt_en = ue;
    ps_ureg_wrt_a  = ua;
    ps_ureg_dt     = ud;
    step();
    idle_inputs();
  endtask

  // Pop every pending expectation and compare it against the read ports
  task automatic sb_drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ps_rf_rd_a0 = e.a0;
      ps_rf_rd_a1 = e.a1;
      #1;
      chk({e.nm, "_p0"}, rf_dt0, e.d0);
      chk({e.nm, "_p1"}, rf_dt1, e.d1);
    end
  endtask

  initial begin
    logic [15:0] exp_n1;

    vecs[0] = '{"alu_r1",   4'h1, 3'b001, 16'h1001, 16'h0,    16'h0,    1'b0, 4'h0, 16'h0,    4'h1, 16'h1001, 4'h1, 16'h1001};
    vecs[1] = '{"mul_r4",   4'h4, 3'b010, 16'h0,    16'h4444, 16'h0,    1'b0, 4'h0, 16'h0,    4'h4, 16'h4444, 4'h1, 16'h1001};
    vecs[2] = '{"shf_r6",   4'h6, 3'b100, 16'h0,    16'h0,    16'h6666, 1'b0, 4'h0, 16'h0,    4'h6, 16'h6666, 4'h4, 16'h4444};
    vecs[3] = '{"xfer_r0",  4'h0, 3'b000, 16'h0,    16'h0,    16'h0,    1'b1, 4'h0, 16'hC0DE, 4'h0, 16'hC0DE, 4'h6, 16'h6666};
    vecs[4] = '{"same_r7",  4'h7, 3'b100, 16'h0,    16'h0,    16'h00F0, 1'b1, 4'h7, 16'hBEEF, 4'h7, 16'h00F0, 4'h7, 16'h00F0};
    vecs[5] = '{"diff_r78", 4'h7, 3'b100, 16'h0,    16'h0,    16'h00F0, 1'b1, 4'h8, 16'hBEEF, 4'h7, 16'h00F0, 4'h8, 16'hBEEF};
    vecs[6] = '{"alu_r15",  4'hF, 3'b001, 16'hFFFF, 16'h0,    16'h0,    1'b0, 4'h0, 16'h0,    4'hF, 16'hFFFF, 4'h0, 16'hC0DE};
    vecs[7] = '{"dual_r2",  4'h0, 3'b000, 16'h0,    16'h0,    16'h0,    1'b1, 4'h2, 16'h7E7E, 4'h2, 16'h7E7E, 4'h2, 16'h7E7E};

    rst = 1'b0;
    idle_inputs();
    ps_rf_rd_a0 = 4'h0;
    ps_rf_rd_a1 = 4'h0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // Reset state: every register reads zero, no collision
    for (int i = 0; i < 16; i++) begin
      ps_rf_rd_a0 = 4'(i);
      ps_rf_rd_a1 = 4'(15 - i);
      #1;
      chk($sformatf("rst_r%0d", i), rf_dt0, 16'h0000);
    end
    chk("rst_col", {15'h0, rf_wrt_col}, 16'h0);

    // ALU write latency: decode N, enable N+1, visible N+2
    step();
    ps_rf_wrt_a = 4'h5;
    ps_rf_rd_a0 = 4'h5;
    step();
    ps_rf_wrt_a  = 4'h0;
    ps_rf_wrt_en = 3'b001;
    alu_rf_dt    = 16'hA5A5;
    #1;
`ifdef RF_BYPASS_EN
    exp_n1 = 16'hA5A5;
`else
    exp_n1 = 16'h0000;
`endif
    chk("alu_r5_n1", rf_dt0, exp_n1);
    step();
    idle_inputs();
    chk("alu_r5_n2", rf_dt0, 16'hA5A5);

    // Table-driven writes; expectations queued at drive time, checked afterwards
    for (int v = 0; v < 8; v++) begin
      do_write(vecs[v].wa, vecs[v].en, vecs[v].alu, vecs[v].mul, vecs[v].shf,
               vecs[v].ue, vecs[v].ua, vecs[v].ud);
      sb_q.push_back('{vecs[v].nm, vecs[v].ca0, vecs[v].cd0, vecs[v].ca1, vecs[v].cd1});
      sb_drain();
      chk({vecs[v].nm, "_col"}, {15'h0, rf_wrt_col}, 16'h0);
    end
    // Earlier writes survive later ones
    sb_q.push_back('{"keep", 4'h5, 16'hA5A5, 4'h4, 16'h4444});
    sb_drain();

    // Collision: ALU+MUL to reg3, MUL wins, flag sticks
    do_write(4'h3, 3'b011, 16'h1111, 16'h2222, 16'h0, 1'b0, 4'h0, 16'h0);
    sb_q.push_back('{"col_r3", 4'h3, 16'h2222, 4'h3, 16'h2222});
    sb_drain();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("col_sticky%0d", i), {15'h0, rf_wrt_col}, 16'h1);
    end

    // Asynchronous reset during the shifter commit cycle for reg9
    step();
    ps_rf_wrt_a = 4'h9;
    step();
    ps_rf_wrt_a  = 4'h0;
    ps_rf_wrt_en = 3'b100;
    shf_rf_dt    = 16'h1234;
    ps_rf_rd_a0  = 4'h3;
    ps_rf_rd_a1  = 4'h5;
    #2 rst = 1'b0;
    #1;
    chk("arst_col", {15'h0, rf_wrt_col}, 16'h0);
    chk("arst_r3", rf_dt0, 16'h0000);
    chk("arst_r5", rf_dt1, 16'h0000);
    step();
    idle_inputs();
    step();
    #2 rst = 1'b1;
    step();
    ps_rf_rd_a0 = 4'h9;
    ps_rf_rd_a1 = 4'h7;
    #1;
    chk("arst_r9", rf_dt0, 16'h0000);
    chk("arst_r7", rf_dt1, 16'h0000);
    chk("arst_col_after", {15'h0, rf_wrt_col}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ps_regfile_wb
